// File: rtl/mc_bank_sequencer.sv
// Single-bank DRAM command sequencer: buffers decoded commands in a FIFO and
// releases them onto the DRAM bus when bank state and tRCD/tRAS/tRP allow.
module mc_bank_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int T_RCD      = 3,
    parameter int T_RAS      = 6,
    parameter int T_RP       = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  cmd_decoded,
    input  logic [31:0] address,
    output logic        dram_cmd_valid,
    output logic [3:0]  dram_cmd,
    output logic [31:0] dram_addr,
    output logic        bank_open,
    output logic        fifo_full,
    output logic        overflow,
    output logic        proto_err
);

    localparam logic [3:0] CMD_ACT   = 4'b0001;
    localparam logic [3:0] CMD_READ  = 4'b0010;
    localparam logic [3:0] CMD_WRITE = 4'b0011;
    localparam logic [3:0] CMD_PRE   = 4'b0100;

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CNT_MAX = (T_RCD > T_RAS) ? T_RCD : T_RAS;
    localparam int CW_RAW  = $clog2(CNT_MAX + T_RP + 1);
    localparam int CW      = (CW_RAW > 8) ? CW_RAW : 8;

    typedef enum logic [1:0] {
        CLOSED      = 2'd0,
        ACTIVATING  = 2'd1,
        ACTIVE      = 2'd2,
        PRECHARGING = 2'd3
    } bank_state_t;

    logic [3:0]    fifo_cmd  [FIFO_DEPTH];
    logic [31:0]   fifo_addr [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    bank_state_t   state_reg;
    logic [CW-1:0] act_cnt_reg, pre_cnt_reg;

    logic        in_is_cmd, full, push, pop, issue, discard;
    logic [3:0]  head_cmd;
    logic [31:0] head_addr;
    logic        rcd_ok, ras_ok, rp_ok;
    logic        eff_closed, eff_activating, eff_active, eff_precharging;

    assign in_is_cmd = (cmd_decoded >= CMD_ACT) && (cmd_decoded <= CMD_PRE);
    assign full      = (count_reg == (AW+1)'(FIFO_DEPTH));
    assign push      = in_is_cmd && !full;
    assign head_cmd  = fifo_cmd[rd_ptr_reg];
    assign head_addr = fifo_addr[rd_ptr_reg];
    assign fifo_full = full;

    // The counters start at 1 in the cycle the issuing command is on the bus,
    // so a count of N at the deciding edge puts the follower on the bus at +N.
    assign rcd_ok = (act_cnt_reg >= CW'(T_RCD));
    assign ras_ok = (act_cnt_reg >= CW'(T_RAS));
    assign rp_ok  = (pre_cnt_reg >= CW'(T_RP));

    // Timer expiry is honoured in the same cycle the state register moves on.
    assign eff_active      = (state_reg == ACTIVE) || (state_reg == ACTIVATING && rcd_ok);
    assign eff_activating  = (state_reg == ACTIVATING) && !rcd_ok;
    assign eff_closed      = (state_reg == CLOSED) || (state_reg == PRECHARGING && rp_ok);
    assign eff_precharging = (state_reg == PRECHARGING) && !rp_ok;

    always_comb begin
        issue   = 1'b0;
        discard = 1'b0;
        if (count_reg != '0) begin
            case (head_cmd)
                CMD_ACT: begin
                    if (eff_closed)
                        issue = 1'b1;
                    else if (!eff_precharging)
                        discard = 1'b1;
                end
                CMD_READ, CMD_WRITE: begin
                    if (eff_active)
                        issue = 1'b1;
                    else if (!eff_activating)
                        discard = 1'b1;
                end
                CMD_PRE: begin
                    if (eff_active && ras_ok)
                        issue = 1'b1;
                    else if (!(eff_active || eff_activating))
                        discard = 1'b1;
                end
                default: discard = 1'b1;
            endcase
        end
    end

    assign pop = issue || discard;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_cmd[wr_ptr_reg]  <= cmd_decoded;
            fifo_addr[wr_ptr_reg] <= address;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Bank FSM, timers and registered bus outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= CLOSED;
            act_cnt_reg    <= '0;
            pre_cnt_reg    <= '0;
            dram_cmd_valid <= 1'b0;
            dram_cmd       <= 4'b0000;
            dram_addr      <= '0;
            bank_open      <= 1'b0;
            overflow       <= 1'b0;
            proto_err      <= 1'b0;
        end else begin
            if (issue && head_cmd == CMD_ACT)
                act_cnt_reg <= CW'(1);
            else if (act_cnt_reg < CW'(CNT_MAX))
                act_cnt_reg <= act_cnt_reg + CW'(1);

            if (issue && head_cmd == CMD_PRE)
                pre_cnt_reg <= CW'(1);
            else if (pre_cnt_reg < CW'(T_RP))
                pre_cnt_reg <= pre_cnt_reg + CW'(1);

            if (issue && head_cmd == CMD_ACT)
                state_reg <= ACTIVATING;
            else if (issue && head_cmd == CMD_PRE)
                state_reg <= PRECHARGING;
            else if (state_reg == ACTIVATING && rcd_ok)
                state_reg <= ACTIVE;
            else if (state_reg == PRECHARGING && rp_ok)
                state_reg <= CLOSED;

            dram_cmd_valid <= issue;
            dram_cmd       <= issue ? head_cmd : 4'b0000;
            if (issue)
                dram_addr <= head_addr;
            bank_open <= (state_reg == ACTIVATING) || (state_reg == ACTIVE);
            overflow  <= in_is_cmd && full;
            proto_err <= discard;
        end
    end

endmodule

// File: tb/tb_mc_bank_sequencer.sv
// Directed bench for mc_bank_sequencer: per-cycle output log, then checks
// against hand-computed bus timelines for each scenario.
module tb_mc_bank_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  cmd_decoded = 4'b0000;
    logic [31:0] address = '0;
    logic        dram_cmd_valid;
    logic [3:0]  dram_cmd;
    logic [31:0] dram_addr;
    logic        bank_open, fifo_full, overflow, proto_err;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = -1;

    logic        lv  [32];
    logic [3:0]  lc  [32];
    logic [31:0] la  [32];
    logic        lbo [32];
    logic        lff [32];
    logic        lov [32];
    logic        lpe [32];

    mc_bank_sequencer dut (
        .clk(clk), .reset(reset), .cmd_decoded(cmd_decoded), .address(address),
        .dram_cmd_valid(dram_cmd_valid), .dram_cmd(dram_cmd), .dram_addr(dram_addr),
        .bank_open(bank_open), .fifo_full(fifo_full), .overflow(overflow),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cyc >= 0 && cyc < 32) begin
            lv[cyc]  = dram_cmd_valid;
            lc[cyc]  = dram_cmd;
            la[cyc]  = dram_addr;
            lbo[cyc] = bank_open;
            lff[cyc] = fifo_full;
            lov[cyc] = overflow;
            lpe[cyc] = proto_err;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input string scn, input int i, input logic v, input logic [3:0] c,
                       input logic [31:0] a);
        chk($sformatf("%s_valid_c%0d", scn, i), 32'(lv[i]), 32'(v));
        chk($sformatf("%s_cmd_c%0d", scn, i), 32'(lc[i]), 32'(c));
        if (v)
            chk($sformatf("%s_addr_c%0d", scn, i), la[i], a);
    endtask

    task automatic start_scn();
        @(posedge clk); #1;
        reset = 1'b1;
        cmd_decoded = 4'b0000;
        address = '0;
        cyc = -1;
        for (int i = 0; i < 32; i++) begin
            lv[i] = 1'bx; lc[i] = 'x; la[i] = 'x;
            lbo[i] = 1'bx; lff[i] = 1'bx; lov[i] = 1'bx; lpe[i] = 1'bx;
        end
    endtask

    task automatic step(input logic r, input logic [3:0] c, input logic [31:0] a);
        @(posedge clk); #1;
        reset = r;
        cmd_decoded = c;
        address = a;
        cyc++;
    endtask

    task automatic idle_to(input int last);
        while (cyc < last)
            step(1'b0, 4'b0000, 32'h0);
        @(negedge clk); #1;
    endtask

    initial begin
        // Scenario A: ACT at c5, READ at c6
        start_scn();
        repeat (5) step(1'b0, 4'b0000, 32'h0);
        step(1'b0, 4'b0001, 32'h1000_0040);
        step(1'b0, 4'b0010, 32'h2000_0040);
        idle_to(12);
        bus("a", 6, 1'b0, 4'h0, 32'h0);
        bus("a", 7, 1'b1, 4'h1, 32'h1000_0040);
        bus("a", 8, 1'b0, 4'h0, 32'h0);
        bus("a", 9, 1'b0, 4'h0, 32'h0);
        bus("a", 10, 1'b1, 4'h2, 32'h2000_0040);
        bus("a", 11, 1'b0, 4'h0, 32'h0);
        chk("a_bank_open_c5", 32'(lbo[5]), 32'd0);
        chk("a_bank_open_c8", 32'(lbo[8]), 32'd1);
        chk("a_bank_open_c10", 32'(lbo[10]), 32'd1);

        // Scenario B: ACT/READ/WRITE/PRE back-to-back, then a fresh ACT at c9
        start_scn();
        step(1'b0, 4'b0001, 32'h1000_0000);
        step(1'b0, 4'b0010, 32'h2000_0004);
        step(1'b0, 4'b0011, 32'h3000_0008);
        step(1'b0, 4'b0100, 32'h4000_000C);
        repeat (5) step(1'b0, 4'b0000, 32'h0);
        step(1'b0, 4'b0001, 32'h1000_0080);
        idle_to(14);
        bus("b", 1, 1'b0, 4'h0, 32'h0);
        bus("b", 2, 1'b1, 4'h1, 32'h1000_0000);
        bus("b", 4, 1'b0, 4'h0, 32'h0);
        bus("b", 5, 1'b1, 4'h2, 32'h2000_0004);
        bus("b", 6, 1'b1, 4'h3, 32'h3000_0008);
        bus("b", 7, 1'b0, 4'h0, 32'h0);
        chk("b_addr_hold_c7", la[7], 32'h3000_0008);
        bus("b", 8, 1'b1, 4'h4, 32'h4000_000C);
        bus("b", 9, 1'b0, 4'h0, 32'h0);
        bus("b", 10, 1'b0, 4'h0, 32'h0);
        bus("b", 11, 1'b1, 4'h1, 32'h1000_0080);
        for (int i = 0; i < 14; i++)
            chk($sformatf("b_proto_err_c%0d", i), 32'(lpe[i]), 32'd0);

        // Scenario C: READ to a closed bank is discarded, FIFO drains
        start_scn();
        step(1'b0, 4'b0010, 32'h2000_0000);
        step(1'b0, 4'b0000, 32'h0);
        step(1'b0, 4'b0000, 32'h0);
        step(1'b0, 4'b0001, 32'h1000_0000);
        idle_to(7);
        chk("c_proto_err_c1", 32'(lpe[1]), 32'd0);
        chk("c_proto_err_c2", 32'(lpe[2]), 32'd1);
        chk("c_proto_err_c3", 32'(lpe[3]), 32'd0);
        bus("c", 2, 1'b0, 4'h0, 32'h0);
        bus("c", 3, 1'b0, 4'h0, 32'h0);
        bus("c", 4, 1'b0, 4'h0, 32'h0);
        bus("c", 5, 1'b1, 4'h1, 32'h1000_0000);
        chk("c_proto_err_c5", 32'(lpe[5]), 32'd0);

        // Scenario D: ACT stalls on tRP while READs fill the FIFO
        start_scn();
        step(1'b0, 4'b0001, 32'h1000_0100);
        step(1'b0, 4'b0100, 32'h4000_0100);
        repeat (4) step(1'b0, 4'b0000, 32'h0);
        step(1'b0, 4'b0001, 32'h1000_0200);
        step(1'b0, 4'b0010, 32'h2000_0001);
        step(1'b0, 4'b0010, 32'h2000_0002);
        step(1'b0, 4'b0010, 32'h2000_0003);
        step(1'b0, 4'b0010, 32'h2000_0004);
        idle_to(19);
        bus("d", 2, 1'b1, 4'h1, 32'h1000_0100);
        bus("d", 8, 1'b1, 4'h4, 32'h4000_0100);
        chk("d_fifo_full_c9", 32'(lff[9]), 32'd0);
        chk("d_fifo_full_c10", 32'(lff[10]), 32'd1);
        chk("d_fifo_full_c11", 32'(lff[11]), 32'd0);
        chk("d_overflow_c10", 32'(lov[10]), 32'd0);
        chk("d_overflow_c11", 32'(lov[11]), 32'd1);
        chk("d_overflow_c12", 32'(lov[12]), 32'd0);
        bus("d", 10, 1'b0, 4'h0, 32'h0);
        bus("d", 11, 1'b1, 4'h1, 32'h1000_0200);
        bus("d", 12, 1'b0, 4'h0, 32'h0);
        bus("d", 13, 1'b0, 4'h0, 32'h0);
        bus("d", 14, 1'b1, 4'h2, 32'h2000_0001);
        bus("d", 15, 1'b1, 4'h2, 32'h2000_0002);
        bus("d", 16, 1'b1, 4'h2, 32'h2000_0003);
        bus("d", 17, 1'b0, 4'h0, 32'h0);
        bus("d", 18, 1'b0, 4'h0, 32'h0);
        for (int i = 0; i < 19; i++)
            chk($sformatf("d_proto_err_c%0d", i), 32'(lpe[i]), 32'd0);

        // Scenario E: reset with the bank ACTIVE and the FIFO holding PRE/READs
        start_scn();
        step(1'b0, 4'b0001, 32'h1000_0000);
        step(1'b0, 4'b0010, 32'h2000_0010);
        step(1'b0, 4'b0100, 32'h4000_0000);
        step(1'b0, 4'b0010, 32'h2000_0020);
        step(1'b0, 4'b0010, 32'h2000_0030);
        step(1'b0, 4'b0000, 32'h0);
        step(1'b1, 4'b0010, 32'h2000_0040);
        idle_to(14);
        bus("e", 5, 1'b1, 4'h2, 32'h2000_0010);
        chk("e_bank_open_c6", 32'(lbo[6]), 32'd1);
        chk("e_valid_c7", 32'(lv[7]), 32'd0);
        chk("e_cmd_c7", 32'(lc[7]), 32'd0);
        chk("e_addr_c7", la[7], 32'd0);
        chk("e_bank_open_c7", 32'(lbo[7]), 32'd0);
        chk("e_fifo_full_c7", 32'(lff[7]), 32'd0);
        chk("e_overflow_c7", 32'(lov[7]), 32'd0);
        chk("e_proto_err_c7", 32'(lpe[7]), 32'd0);
        for (int i = 8; i < 14; i++) begin
            chk($sformatf("e_valid_c%0d", i), 32'(lv[i]), 32'd0);
            chk($sformatf("e_proto_err_c%0d", i), 32'(lpe[i]), 32'd0);
            chk($sformatf("e_bank_open_c%0d", i), 32'(lbo[i]), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
